// File: rtl/hex_alu_display_ctrl.sv
// Handshaked single-op ALU engine whose registered result is scanned onto a WIDTH/4-digit hex display.
// Optional HEX_DISPLAY_BLANK_EN: blank leading-zero digits (digit 0 always shown).
module hex_alu_display_ctrl #(
    parameter int WIDTH       = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ext_input,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic [WIDTH-1:0]   Z,
    output logic [4:0]         flags,
    output logic [6:0]         seg7,
    output logic [WIDTH/4-1:0] select
);
    localparam int DIGITS = WIDTH / 4;
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;

    state_t             state_r, state_next_s;
    logic               busy_r, done_r;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r, z_r;
    logic [4:0]         flags_r;

    logic [WIDTH:0]     sum_s, diff_s;
    logic [WIDTH-1:0]   alu_z_s;
    logic               c_s, l_s, f_s, zf_s, n_s, add_ovf_s, sub_ovf_s, slt_s;
    logic               is_cmp_s, op_valid_s;

    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r, idx_next_s;
    logic [DIGITS-1:0]  select_r, select_next_s;
    logic [3:0]         nib_s;
    logic               blank_s;

    // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // FSM next state; start is only honoured from IDLE, never queued.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_EXEC;
                else       state_next_s = ST_IDLE;
            end
            ST_EXEC: state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // busy/done registered from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    // ALU: all arithmetic is WIDTH+1 bits so bit WIDTH is carry (ADD) or borrow (SUB/CMP).
    always_comb begin
        sum_s      = {1'b0, a_r} + {1'b0, b_r};
        diff_s     = {1'b0, a_r} - {1'b0, b_r};
        add_ovf_s  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
        sub_ovf_s  = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
        slt_s      = ($signed(a_r) < $signed(b_r));
        alu_z_s    = '0;
        c_s        = 1'b0;
        l_s        = 1'b0;
        f_s        = 1'b0;
        n_s        = 1'b0;
        zf_s       = 1'b0;
        is_cmp_s   = 1'b0;
        op_valid_s = 1'b1;
        case (op_r)
            4'd0: begin
                alu_z_s = sum_s[WIDTH-1:0];
                c_s     = sum_s[WIDTH];
                f_s     = add_ovf_s;
            end
            4'd1, 4'd8: begin
                alu_z_s  = (op_r == 4'd8) ? '0 : diff_s[WIDTH-1:0];
                is_cmp_s = (op_r == 4'd8);
                c_s      = diff_s[WIDTH];
                l_s      = diff_s[WIDTH];
                f_s      = sub_ovf_s;
                n_s      = slt_s;
            end
            4'd2:    alu_z_s = a_r & b_r;
            4'd3:    alu_z_s = a_r | b_r;
            4'd4:    alu_z_s = a_r ^ b_r;
            4'd5:    alu_z_s = ~a_r;
            4'd6:    alu_z_s = {a_r[WIDTH-2:0], 1'b0};
            4'd7:    alu_z_s = {1'b0, a_r[WIDTH-1:1]};
            4'd9:    alu_z_s = b_r;
            default: op_valid_s = 1'b0;
        endcase
        if (is_cmp_s)        zf_s = (a_r == b_r);
        else if (op_valid_s) zf_s = (alu_z_s == '0);
        else                 zf_s = 1'b0;
    end

    // Operand latch in IDLE and result/flag capture in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r    <= 4'd0;
            a_r     <= '0;
            b_r     <= '0;
            z_r     <= '0;
            flags_r <= 5'd0;
        end else begin
            if (state_r == ST_IDLE && start) begin
                op_r <= ext_input;
                a_r  <= a_in;
                b_r  <= b_in;
            end
            if (state_r == ST_EXEC) begin
                z_r     <= alu_z_s;
                flags_r <= {c_s, l_s, f_s, zf_s, n_s};
            end
        end
    end

    // Next digit index and its one-hot active-low enable.
    always_comb begin
        select_next_s = '1;
        if (idx_r == IDX_W'(DIGITS - 1)) idx_next_s = '0;
        else                             idx_next_s = idx_r + IDX_W'(1);
        for (int d = 0; d < DIGITS; d++) begin
            select_next_s[d] = (idx_next_s != IDX_W'(d));
        end
    end

    // Refresh timer: the digit advances when the counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= '0;
            idx_r    <= '0;
            select_r <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else if (cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_r    <= '0;
            idx_r    <= idx_next_s;
            select_r <= select_next_s;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

    // Digit glyph decoded straight from z_r so a new result appears on the current digit at once.
    always_comb begin
        nib_s   = 4'd0;
        blank_s = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_r == IDX_W'(d)) nib_s = z_r[4*d +: 4];
        end
`ifdef HEX_DISPLAY_BLANK_EN
        if (idx_r != '0) begin
            blank_s = 1'b1;
            for (int d = 0; d < DIGITS; d++) begin
                if (IDX_W'(d) >= idx_r && z_r[4*d +: 4] != 4'd0) blank_s = 1'b0;
            end
        end else begin
            blank_s = 1'b0;
        end
`else
        blank_s = 1'b0;
`endif
        if (blank_s) seg7 = 7'b1111111;
        else         seg7 = hex_to_seg(nib_s);
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign A      = a_r;
    assign B      = b_r;
    assign Z      = z_r;
    assign flags  = flags_r;
    assign select = select_r;

endmodule
